service_4_alarm_setter: RTL and testbench

//  Writer side of the alarm-time interface: user edits an HH:MM BCD alarm with push buttons and commits it to alarm[15:0],

---
 rtl/service_4_alarm_setter_pkg.sv | 20 ++
 rtl/service_4_alarm_setter_if.sv | 19 +
 rtl/service_4_alarm_setter_bcd_time_step.sv | 35 +++
 rtl/service_4_alarm_setter.sv | 141 ++++++++++++++
 tb/tb_service_4_alarm_setter.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/service_4_alarm_setter_pkg.sv
// Shared codes for the Service_4 alarm setter: alarm-check states, edit field select, BCD field slices.
package service_4_alarm_setter_pkg;
  typedef enum logic [2:0] {S0 = 3'b000, S1 = 3'b001, S2 = 3'b010, S3 = 3'b100} alarm_state_e;
  typedef enum logic [1:0] {SEL_IDLE = 2'b00, SEL_HR = 2'b01, SEL_MIN = 2'b10} edit_sel_e;

  localparam int HR_HI  = 15;
  localparam int HR_LO  = 8;
  localparam int MIN_HI = 7;
  localparam int MIN_LO = 0;

  localparam int BTN_U   = 0;
  localparam int BTN_D   = 1;
  localparam int BTN_M   = 2;
  localparam int BTN_SNZ = 3;
  localparam int NUM_BTN = 4;

  function automatic logic [7:0] bcd_to_bin(input logic [7:0] bcd);
    return 8'(bcd[7:4]) * 8'd10 + 8'(bcd[3:0]);
  endfunction
endpackage

// File: rtl/service_4_alarm_setter_if.sv
// Button inputs, alarm-check state and alarm/display outputs of the alarm setter.
interface service_4_alarm_setter_if;
  logic        enable;
  logic        push_u;
  logic        push_d;
  logic        push_m;
  logic        snooze;
  logic [2:0]  alarm_state;
  logic [15:0] alarm;
  logic        alarm_valid;
  logic [15:0] edit_time;
  logic [1:0]  edit_sel;
  logic        blink;

  modport master (output enable, push_u, push_d, push_m, snooze, alarm_state,
                  input  alarm, alarm_valid, edit_time, edit_sel, blink);
  modport slave  (input  enable, push_u, push_d, push_m, snooze, alarm_state,
                  output alarm, alarm_valid, edit_time, edit_sel, blink);
endinterface

// File: rtl/service_4_alarm_setter_bcd_time_step.sv
// Combinational BCD add/subtract of one time field modulo MOD; carry flags wrap (or borrow).
module service_4_alarm_setter_bcd_time_step
  import service_4_alarm_setter_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic [7:0] val,
  input  logic [5:0] step,
  input  logic       dec,
  output logic [7:0] nxt,
  output logic       carry
);
  logic [7:0] bin, step8, sum, res;

  always_comb begin
    bin   = bcd_to_bin(val);
    step8 = 8'(step);
    sum   = bin + step8;
    res   = sum;
    carry = 1'b0;
    if (dec) begin
      if (step8 > bin) begin
        res   = bin + 8'(MOD) - step8;
        carry = 1'b1;
      end else begin
        res = bin - step8;
      end
    end else if (sum >= 8'(MOD)) begin
      res   = sum - 8'(MOD);
      carry = 1'b1;
    end
  end

  assign nxt = {4'(res / 8'd10), 4'(res % 8'd10)};
endmodule

// File: rtl/service_4_alarm_setter.sv
// Alarm-time writer: push-button HH:MM BCD editor with commit, blink and display feed.
// Optional snooze re-arm is built when SERVICE_4_SNOOZE_EN is defined.
module service_4_alarm_setter
  import service_4_alarm_setter_pkg::*;
#(
  parameter int BLINK_DIV  = 500,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                       s2clk,
  input  logic                       reset,
  service_4_alarm_setter_if.slave    bus
);
  localparam int CW = $clog2(BLINK_DIV + 1);

  logic [NUM_BTN-1:0] btn_raw, btn_pulse;
  assign btn_raw = {bus.snooze, bus.push_m, bus.push_d, bus.push_u};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    logic [2:0] sync_q, sync_d;
    always_comb sync_d = {sync_q[1:0], btn_raw[i]};
    always_ff @(posedge s2clk or posedge reset)
      if (reset) sync_q <= '0;
      else       sync_q <= sync_d;
    assign btn_pulse[i] = sync_q[1] & ~sync_q[2];
  end

  edit_sel_e     state_q, state_d;
  logic [15:0]   edit_q, edit_d, alarm_q, alarm_d;
  logic          valid_q, valid_d, blink_q, blink_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          u, d, m, ud, snz_go, snz_sel;
  logic [15:0]   step_src;
  logic [7:0]    hr_nxt, min_nxt;
  logic          min_carry, hr_carry, unused_hr_carry;

  assign u  = btn_pulse[BTN_U];
  assign d  = btn_pulse[BTN_D];
  assign m  = btn_pulse[BTN_M];
  assign ud = u ^ d;

`ifdef SERVICE_4_SNOOZE_EN
  assign snz_go = btn_pulse[BTN_SNZ] && (bus.alarm_state == S2) && valid_q;
`else
  logic unused_snz;
  assign snz_go     = 1'b0;
  assign unused_snz = ^{btn_pulse[BTN_SNZ], bus.alarm_state};
`endif

  // Steppers are shared: in IDLE they form the snooze adder on alarm, otherwise +/-1 on the edit buffer.
  assign snz_sel  = (state_q == SEL_IDLE);
  assign step_src = snz_sel ? alarm_q : edit_q;

  service_4_alarm_setter_bcd_time_step #(.MOD(60)) u_min_step (
    .val   (step_src[MIN_HI:MIN_LO]),
    .step  (snz_sel ? 6'(SNOOZE_MIN) : 6'd1),
    .dec   (~snz_sel & d),
    .nxt   (min_nxt),
    .carry (min_carry)
  );

  service_4_alarm_setter_bcd_time_step #(.MOD(24)) u_hr_step (
    .val   (step_src[HR_HI:HR_LO]),
    .step  (snz_sel ? {5'd0, min_carry} : 6'd1),
    .dec   (~snz_sel & d),
    .nxt   (hr_nxt),
    .carry (hr_carry)
  );
  assign unused_hr_carry = hr_carry;

  always_comb begin
    state_d = state_q;
    edit_d  = edit_q;
    alarm_d = alarm_q;
    valid_d = valid_q;
    unique case (state_q)
      SEL_IDLE: begin
        if (m && bus.enable) begin
          state_d = SEL_HR;
          edit_d  = alarm_q;
        end else if (snz_go) begin
          alarm_d = {hr_nxt, min_nxt};
        end
      end
      SEL_HR: begin
        if (!bus.enable) state_d = SEL_IDLE;
        else if (m)      state_d = SEL_MIN;
        else if (ud)     edit_d[HR_HI:HR_LO] = hr_nxt;
      end
      SEL_MIN: begin
        if (!bus.enable) begin
          state_d = SEL_IDLE;
        end else if (m) begin
          alarm_d = edit_q;
          valid_d = 1'b1;
          state_d = SEL_IDLE;
        end else if (ud) begin
          edit_d[MIN_HI:MIN_LO] = min_nxt;
        end
      end
      default: state_d = SEL_IDLE;
    endcase
  end

  // Counter is held at zero on the entry edge too, so the first half-period is a full BLINK_DIV.
  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    blink_d = blink_q;
    if (state_q == SEL_IDLE || state_d == SEL_IDLE) begin
      cnt_d   = '0;
      blink_d = 1'b0;
    end else if (cnt_q == CW'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      blink_d = ~blink_q;
    end
  end

  always_ff @(posedge s2clk or posedge reset) begin
    if (reset) begin
      state_q <= SEL_IDLE;
      edit_q  <= '0;
      alarm_q <= '0;
      valid_q <= 1'b0;
      blink_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      edit_q  <= edit_d;
      alarm_q <= alarm_d;
      valid_q <= valid_d;
      blink_q <= blink_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.alarm       = alarm_q;
  assign bus.alarm_valid = valid_q;
  assign bus.edit_time   = edit_q;
  assign bus.edit_sel    = state_q;
  assign bus.blink       = blink_q;
endmodule

// File: tb/tb_service_4_alarm_setter.sv
// Directed bench for the alarm setter; expected snapshots are queued by stimulus and checked by a monitor.
module tb_service_4_alarm_setter;
  import service_4_alarm_setter_pkg::*;

  localparam int BLINK_DIV = 8;
  localparam logic [3:0] BU = 4'b0001, BD = 4'b0010, BM = 4'b0100, BS = 4'b1000;

  logic s2clk = 1'b0;
  logic reset = 1'b1;
  always #5 s2clk = ~s2clk;

  service_4_alarm_setter_if bus ();

  service_4_alarm_setter #(.BLINK_DIV(BLINK_DIV), .SNOOZE_MIN(5)) dut (
    .s2clk (s2clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [15:0] alarm;
    logic        valid;
    logic [15:0] edit;
    logic [1:0]  sel;
    logic        blink;
    bit          chk_blink;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic exp_push(input string tag, input logic [15:0] a, input logic v,
                          input logic [15:0] e, input logic [1:0] s, input logic b, input bit cb);
    exp_t x;
    x.tag = tag; x.alarm = a; x.valid = v; x.edit = e; x.sel = s; x.blink = b; x.chk_blink = cb;
    exp_q.push_back(x);
  endtask

  always @(negedge s2clk) begin
    while (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      n_cmp++;
      if (bus.alarm !== x.alarm || bus.alarm_valid !== x.valid || bus.edit_time !== x.edit ||
          bus.edit_sel !== x.sel || (x.chk_blink && bus.blink !== x.blink)) begin
        n_err++;
        $display("FAIL %s: got alarm=%h valid=%b edit=%h sel=%b blink=%b; want alarm=%h valid=%b edit=%h sel=%b blink=%b (checked=%0d)",
                 x.tag, bus.alarm, bus.alarm_valid, bus.edit_time, bus.edit_sel, bus.blink,
                 x.alarm, x.valid, x.edit, x.sel, x.blink, x.chk_blink);
      end
    end
  end

  task automatic set_btn(input logic [3:0] v);
    {bus.snooze, bus.push_m, bus.push_d, bus.push_u} = v;
  endtask

  task automatic press(input logic [3:0] v);
    @(posedge s2clk); #1;
    set_btn(v);
    repeat (2) @(posedge s2clk); #1;
    set_btn(4'b0);
    repeat (3) @(posedge s2clk); #1;
  endtask

  task automatic press_n(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) press(v);
  endtask

  logic [15:0] snz_alarm;
  logic        prev_blink;
  bit          rise_seen;

  initial begin
`ifdef SERVICE_4_SNOOZE_EN
    snz_alarm = 16'h0003;
`else
    snz_alarm = 16'h2358;
`endif
    bus.enable = 1'b0;
    bus.alarm_state = S0;
    set_btn(4'b0);
    repeat (3) @(posedge s2clk); #1;
    exp_push("reset", 16'h0000, 1'b0, 16'h0000, 2'b00, 1'b0, 1);
    @(posedge s2clk); #1;
    reset = 1'b0;
    bus.enable = 1'b1;

    press(BM); exp_push("enter_hr",  16'h0000, 1'b0, 16'h0000, 2'b01, 1'b0, 0);
    press(BU); exp_push("hr_up1",    16'h0000, 1'b0, 16'h0100, 2'b01, 1'b0, 0);
    press(BU); exp_push("hr_up2",    16'h0000, 1'b0, 16'h0200, 2'b01, 1'b0, 0);
    press(BM); exp_push("to_min",    16'h0000, 1'b0, 16'h0200, 2'b10, 1'b0, 0);
    press(BD); exp_push("min_00_dn", 16'h0000, 1'b0, 16'h0259, 2'b10, 1'b0, 0);
    press(BM); exp_push("commit1",   16'h0259, 1'b1, 16'h0259, 2'b00, 1'b0, 1);

    press(BM);      exp_push("reenter",   16'h0259, 1'b1, 16'h0259, 2'b01, 1'b0, 0);
    press_n(BD, 2); exp_push("hr_to_00",  16'h0259, 1'b1, 16'h0059, 2'b01, 1'b0, 0);
    press(BD);      exp_push("hr_00_dn",  16'h0259, 1'b1, 16'h2359, 2'b01, 1'b0, 0);
    press(BU);      exp_push("hr_23_up",  16'h0259, 1'b1, 16'h0059, 2'b01, 1'b0, 0);
    press(BD);
    press(BM | BU); exp_push("m_wins",    16'h0259, 1'b1, 16'h2359, 2'b10, 1'b0, 0);
    press(BU);      exp_push("min_59_up", 16'h0259, 1'b1, 16'h2300, 2'b10, 1'b0, 0);
    press_n(BD, 15); exp_push("min_45",   16'h0259, 1'b1, 16'h2345, 2'b10, 1'b0, 0);
    press(BU | BD); exp_push("ud_same",   16'h0259, 1'b1, 16'h2345, 2'b10, 1'b0, 0);

    // Held button: one step only.
    @(posedge s2clk); #1; bus.push_u = 1'b1;
    repeat (10) @(posedge s2clk); #1; bus.push_u = 1'b0;
    repeat (3) @(posedge s2clk); #1;
    exp_push("held_u", 16'h0259, 1'b1, 16'h2346, 2'b10, 1'b0, 0);
    // Bounce with two distinct rises: two steps.
    bus.push_u = 1'b1; repeat (2) @(posedge s2clk); #1;
    bus.push_u = 1'b0; repeat (2) @(posedge s2clk); #1;
    bus.push_u = 1'b1; repeat (2) @(posedge s2clk); #1;
    bus.push_u = 1'b0; repeat (3) @(posedge s2clk); #1;
    exp_push("bounce_u", 16'h0259, 1'b1, 16'h2348, 2'b10, 1'b0, 0);
    press_n(BU, 10); exp_push("min_58",   16'h0259, 1'b1, 16'h2358, 2'b10, 1'b0, 0);
    press(BM);       exp_push("commit2",  16'h2358, 1'b1, 16'h2358, 2'b00, 1'b0, 1);

    press(BM);
    press_n(BU, 8);  exp_push("hr_0758",  16'h2358, 1'b1, 16'h0758, 2'b01, 1'b0, 0);
    press(BM);
    press_n(BD, 28); exp_push("min_0730", 16'h2358, 1'b1, 16'h0730, 2'b10, 1'b0, 0);
    bus.enable = 1'b0;
    @(posedge s2clk); #1;
    exp_push("abandon", 16'h2358, 1'b1, 16'h0730, 2'b00, 1'b0, 1);

    bus.alarm_state = S2;
    press(BS); exp_push("snooze_s2", snz_alarm, 1'b1, 16'h0730, 2'b00, 1'b0, 1);
    bus.alarm_state = S1;
    press(BS); exp_push("snooze_s1", snz_alarm, 1'b1, 16'h0730, 2'b00, 1'b0, 1);

    bus.enable = 1'b1;
    press(BM); exp_push("enter_snz", snz_alarm, 1'b1, snz_alarm, 2'b01, 1'b0, 0);
    press(BM);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.alarm !== 16'h0000 || bus.alarm_valid !== 1'b0 || bus.edit_time !== 16'h0000 ||
        bus.edit_sel !== 2'b00 || bus.blink !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: got alarm=%h valid=%b edit=%h sel=%b blink=%b",
               bus.alarm, bus.alarm_valid, bus.edit_time, bus.edit_sel, bus.blink);
    end
    exp_push("reset_mid", 16'h0000, 1'b0, 16'h0000, 2'b00, 1'b0, 1);
    repeat (2) @(posedge s2clk); #1;
    reset = 1'b0;

    press(BM);
    prev_blink = bus.blink;
    rise_seen  = 1'b0;
    for (int i = 0; i < 4 * BLINK_DIV + 10; i++) begin
      @(posedge s2clk); #1;
      if (bus.blink && !prev_blink) begin
        rise_seen = 1'b1;
        break;
      end
      prev_blink = bus.blink;
    end
    n_cmp++;
    if (!rise_seen) begin
      n_err++;
      $display("FAIL blink_wait: no blink rise within %0d cycles", 4 * BLINK_DIV + 10);
    end
    exp_push("blink_rise", 16'h0000, 1'b0, 16'h0000, 2'b01, 1'b1, 1);
    repeat (BLINK_DIV - 1) @(posedge s2clk); #1;
    exp_push("blink_hold", 16'h0000, 1'b0, 16'h0000, 2'b01, 1'b1, 1);
    @(posedge s2clk); #1;
    exp_push("blink_fall", 16'h0000, 1'b0, 16'h0000, 2'b01, 1'b0, 1);
    repeat (BLINK_DIV) @(posedge s2clk); #1;
    exp_push("blink_period", 16'h0000, 1'b0, 16'h0000, 2'b01, 1'b1, 1);

    @(posedge s2clk); #1;
    @(negedge s2clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
